if_id_pipe_reg: RTL and testbench

- Parametrised, elastic successor to the plain IF/ID pipeline register.
- Carries instruction, PC, PC+4 and branch-select from fetch to decode.
- Adds a valid/ready handshake, hazard stall, flush and NOP bubble insertion.
- Uses a 2-entry skid buffer, so `in_ready_o` is registered and never combinationally dependent on `stall_i`.

---
 rtl/if_id_pkg.sv | 21 ++
 rtl/pipe_skid_buf.sv | 56 +++++
 rtl/if_id_pipe_reg.sv | 79 +++++++
 tb/tb_if_id_pipe_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared IF/ID payload layout and defaults for the elastic fetch-to-decode register.
package if_id_pkg;

   localparam int IF_ID_XLEN = 32;
   localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0013;

   // Field order matches the flat packing used inside if_id_pipe_reg: {ins, pc, pc4, br_sel}
   typedef struct packed {
      logic [IF_ID_XLEN-1:0] ins;
      logic [IF_ID_XLEN-1:0] pc;
      logic [IF_ID_XLEN-1:0] pc4;
      logic                  br_sel;
   } if_id_payload_t;

   function automatic int if_id_payload_w(input int xlen);
      return 3 * xlen + 1;
   endfunction

   localparam int IF_ID_PAYLOAD_W = $bits(if_id_payload_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; in_ready is a flop output.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic         main_valid;
   logic [W-1:0] main_data;
   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         accept;
   logic         consume;

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign accept    = in_valid & ~skid_valid;
   assign consume   = main_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || consume) begin
         // Skid holds the older payload, so it always wins over the input
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/if_id_pipe_reg.sv
// Elastic IF/ID pipeline register: skid-buffered handshake, stall, flush, NOP bubbles.
// Optional saturating stall/flush counters are built when IFID_PERF_CNT_EN is defined.
module if_id_pipe_reg
   import if_id_pkg::*;
#(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] NOP_INS = XLEN'(NOP_INS_DEFAULT),
   parameter int              CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [XLEN-1:0]  ins_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  pc4_i,
   input  logic             br_sel_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   output logic [XLEN-1:0]  ins_o,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  pc4_o,
   output logic             br_sel_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int PW = if_id_payload_w(XLEN);

   logic [PW-1:0] in_data;
   logic [PW-1:0] out_data;
   logic          out_valid;

   assign in_data = {ins_i, pc_i, pc4_i, br_sel_i};

   pipe_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .in_valid  (in_valid_i),
      .in_ready  (in_ready_o),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (~stall_i)
   );

   // Data regs are not cleared on flush, so masking on valid keeps bubbles clean
   assign out_valid_o = out_valid;
   assign ins_o       = out_valid ? out_data[3*XLEN -: XLEN] : NOP_INS;
   assign pc_o        = out_data[2*XLEN -: XLEN];
   assign pc4_o       = out_data[XLEN -: XLEN];
   assign br_sel_o    = out_valid & out_data[0];

`ifdef IFID_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && stall_i && !flush_i && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_i && !(&flush_cnt))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign flush_cnt_o = flush_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg; counter expectations follow IFID_PERF_CNT_EN.
module tb_if_id_pipe_reg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [XLEN-1:0]  ins_i, pc_i, pc4_i;
   logic             br_sel_i;
   logic             stall_i;
   logic             flush_i;
   logic             out_valid_o;
   logic [XLEN-1:0]  ins_o, pc_o, pc4_o;
   logic             br_sel_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   if_id_pipe_reg #(.XLEN(XLEN), .NOP_INS(NOP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .ins_i(ins_i), .pc_i(pc_i), .pc4_i(pc4_i), .br_sel_i(br_sel_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .out_valid_o(out_valid_o), .ins_o(ins_o), .pc_o(pc_o), .pc4_o(pc4_o),
      .br_sel_o(br_sel_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic br, input logic st, input logic fl);
      in_valid_i = v;
      pc_i       = pc;
      pc4_i      = pc + 32'd4;
      ins_i      = ins;
      br_sel_i   = br;
      stall_i    = st;
      flush_i    = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expect a valid output with the given pc/ins/br and ready state.
   task automatic expect_valid(input string name, input logic [31:0] pc, input logic [31:0] ins,
                               input logic br, input logic rdy);
      n_cmp++;
      if ({out_valid_o, pc_o, pc4_o, ins_o, br_sel_o, in_ready_o} !==
          {1'b1, pc, pc + 32'd4, ins, br, rdy}) begin
         n_bad++;
         $display("FAIL %s: got v=%b pc=%h pc4=%h ins=%h br=%b rdy=%b, want v=1 pc=%h pc4=%h ins=%h br=%b rdy=%b",
                  name, out_valid_o, pc_o, pc4_o, ins_o, br_sel_o, in_ready_o,
                  pc, pc + 32'd4, ins, br, rdy);
      end
   endtask

   task automatic expect_bubble(input string name, input logic rdy);
      n_cmp++;
      if ({out_valid_o, ins_o, br_sel_o, in_ready_o} !== {1'b0, NOP, 1'b0, rdy}) begin
         n_bad++;
         $display("FAIL %s: got v=%b ins=%h br=%b rdy=%b, want v=0 ins=%h br=0 rdy=%b",
                  name, out_valid_o, ins_o, br_sel_o, in_ready_o, NOP, rdy);
      end
   endtask

   task automatic expect_cnt(input string name, input logic [CNT_W-1:0] st, input logic [CNT_W-1:0] fl);
      logic [CNT_W-1:0] st_e, fl_e;
`ifdef IFID_PERF_CNT_EN
      st_e = st;
      fl_e = fl;
`else
      st_e = '0;
      fl_e = '0;
`endif
      n_cmp++;
      if (stall_cnt_o !== st_e || flush_cnt_o !== fl_e) begin
         n_bad++;
         $display("FAIL %s: got stall_cnt=%0d flush_cnt=%0d, want stall_cnt=%0d flush_cnt=%0d",
                  name, stall_cnt_o, flush_cnt_o, st_e, fl_e);
      end
   endtask

   task automatic test_reset();
      drive(1'b1, 32'h100, 32'hDEAD, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid_o, ins_o, pc_o, pc4_o, br_sel_o, in_ready_o} !== {1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_state: got v=%b ins=%h pc=%h pc4=%h br=%b rdy=%b, want v=0 ins=%h pc=0 pc4=0 br=0 rdy=1",
                  out_valid_o, ins_o, pc_o, pc4_o, br_sel_o, in_ready_o, NOP);
      end
      expect_cnt("reset_cnt", 4'd0, 4'd0);
      tick();
      expect_bubble("reset_idle", 1'b1);
   endtask

   task automatic test_streaming();
      drive(1'b1, 32'h0, 32'hA, 1'b0, 1'b0, 1'b0);
      tick();
      expect_valid("stream_0", 32'h0, 32'hA, 1'b0, 1'b1);
      drive(1'b1, 32'h4, 32'hB, 1'b1, 1'b0, 1'b0);
      tick();
      expect_valid("stream_4", 32'h4, 32'hB, 1'b1, 1'b1);
      drive(1'b1, 32'h8, 32'hC, 1'b0, 1'b0, 1'b0);
      tick();
      expect_valid("stream_8", 32'h8, 32'hC, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_bubble("stream_drain", 1'b1);
   endtask

   task automatic test_stall_skid();
      drive(1'b1, 32'h10, 32'h110, 1'b0, 1'b0, 1'b0);
      tick();
      expect_valid("skid_load10", 32'h10, 32'h110, 1'b0, 1'b1);
      drive(1'b1, 32'h14, 32'h114, 1'b1, 1'b1, 1'b0);
      tick();
      expect_valid("skid_stall1", 32'h10, 32'h110, 1'b0, 1'b0);
      drive(1'b1, 32'h18, 32'h118, 1'b0, 1'b1, 1'b0);
      tick();
      expect_valid("skid_stall2", 32'h10, 32'h110, 1'b0, 1'b0);
      tick();
      expect_valid("skid_stall3", 32'h10, 32'h110, 1'b0, 1'b0);
      expect_cnt("skid_cnt", 4'd3, 4'd0);
      drive(1'b1, 32'h18, 32'h118, 1'b0, 1'b0, 1'b0);
      tick();
      expect_valid("skid_out14", 32'h14, 32'h114, 1'b1, 1'b1);
      tick();
      expect_valid("skid_out18", 32'h18, 32'h118, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_bubble("skid_drain", 1'b1);
   endtask

   task automatic test_flush_skid_full();
      drive(1'b1, 32'h30, 32'h130, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h34, 32'h134, 1'b0, 1'b1, 1'b0);
      tick();
      expect_valid("flush_prefill", 32'h30, 32'h130, 1'b1, 1'b0);
      drive(1'b1, 32'h20, 32'h120, 1'b1, 1'b1, 1'b1);
      tick();
      expect_bubble("flush_skid_full", 1'b1);
      expect_cnt("flush_cnt1", 4'd4, 4'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_bubble("flush_no_20", 1'b1);
   endtask

   task automatic test_flush_accept_and_stall();
      drive(1'b1, 32'h40, 32'h140, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h44, 32'h144, 1'b1, 1'b0, 1'b1);
      tick();
      expect_bubble("flush_discard_in", 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_bubble("flush_no_44", 1'b1);
      drive(1'b1, 32'h50, 32'h150, 1'b1, 1'b0, 1'b0);
      tick();
      expect_valid("fs_load50", 32'h50, 32'h150, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      tick();
      expect_bubble("flush_and_stall", 1'b1);
      expect_cnt("flush_stall_cnt", 4'd4, 4'd3);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_saturation();
      drive(1'b1, 32'h60, 32'h160, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      expect_valid("sat_hold60", 32'h60, 32'h160, 1'b0, 1'b1);
      expect_cnt("sat_cnt", 4'd15, 4'd3);
      tick();
      expect_cnt("sat_cnt_hold", 4'd15, 4'd3);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_bubble("sat_release", 1'b1);
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, 32'h70, 32'h170, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h74, 32'h174, 1'b1, 1'b1, 1'b0);
      tick();
      expect_valid("rst_prefill", 32'h70, 32'h170, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid_o, ins_o, pc_o, br_sel_o, in_ready_o} !== {1'b0, NOP, 32'h0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_mid_stall: got v=%b ins=%h pc=%h br=%b rdy=%b, want v=0 ins=%h pc=0 br=0 rdy=1",
                  out_valid_o, ins_o, pc_o, br_sel_o, in_ready_o, NOP);
      end
      expect_cnt("reset_mid_cnt", 4'd0, 4'd0);
      tick();
      expect_bubble("reset_mid_idle", 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_streaming();
      test_stall_skid();
      test_flush_skid_full();
      test_flush_accept_and_stall();
      test_saturation();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
